// File: rtl/fetch_unit.sv
// Instruction fetch stage for core_v1.
// Holds the PC, issues one instruction-memory request at a time, presents
// fetched instructions to decode over valid/ready, and flushes wrong-path
// fetches on branch/jump redirects. A 1-entry skid buffer catches a response
// that lands while decode is stalling.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets to TRAP_VECTOR and pulse misalign_trap.

module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_ctrl,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        redirect;
    logic [31:0] sel_target;
    logic [31:0] new_pc;
    logic        accept;
    logic        misaligned;

    // Redirect selection: jump wins over branch; target low bits are never fetched.
    always_comb begin
        redirect   = branch_ctrl | jump;
        sel_target = jump ? jump_target : branch_target;
        accept     = if_valid & if_ready;
        misaligned = (sel_target[1:0] != 2'b00);
`ifdef FETCH_MISALIGN_TRAP_EN
        new_pc     = misaligned ? TRAP_VECTOR : sel_target;
`else
        new_pc     = sel_target & ~32'h0000_0003;
`endif
    end

    // Fetch FSM, request port, output register and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_VECTOR;
            if_valid      <= 1'b0;
            if_pc         <= 32'h0000_0000;
            if_instr      <= NOP_INSTR;
            skid_valid    <= 1'b0;
            skid_pc       <= 32'h0000_0000;
            skid_instr    <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
            // Drain: an accepted transfer is refilled from the skid or emptied.
            if (accept) begin
                if (skid_valid) begin
                    if_pc      <= skid_pc;
                    if_instr   <= skid_instr;
                    skid_valid <= 1'b0;
                end else begin
                    if_valid <= 1'b0;
                    if_instr <= NOP_INSTR;
                end
            end

            case (state)
                BOOT: state <= IDLE;
                IDLE: begin
                    // Only fetch when a response is guaranteed a place to land.
                    if (!skid_valid) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                        pc       <= pc + 32'd4;
                        if (!if_valid || accept) begin
                            if_valid <= 1'b1;
                            if_pc    <= imem_addr;
                            if_instr <= imem_rdata;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_pc    <= imem_addr;
                            skid_instr <= imem_rdata;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase

            // Redirect overrides everything above: flush and retarget the PC.
            if (redirect) begin
                pc         <= new_pc;
                if_valid   <= 1'b0;
                if_instr   <= NOP_INSTR;
                skid_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                misalign_trap <= misaligned;
`endif
                if (state == IDLE) begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end else if (state == WAIT && !imem_ack) begin
                    state <= DROP;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small latency-programmable memory model
// answers requests; the main thread steps cycle by cycle and compares outputs
// against hand-derived values.

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_ctrl;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;
    int mem_cnt  = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_ctrl  (branch_ctrl),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap(misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: ack mem_lat cycles after req is first seen, one-cycle pulse.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end else if (imem_ack) begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end else if (imem_req) begin
                mem_cnt++;
                if (mem_cnt == mem_lat + 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = rdata_of(imem_addr);
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in the first IDLE cycle after reset release.
    task automatic restart();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        branch_ctrl   = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        if_ready      = 1'b1;

        // Reset state
        tick();
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_instr", if_instr, NOP);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_trap",  32'(misalign_trap), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("boot_idle_req", 32'(imem_req), 32'd0);

        // Sequential fetch, 1-cycle memory, decode always ready
        tick();
        for (int k = 0; k < 4; k++) begin
            check("seq_req",  32'(imem_req), 32'd1);
            check("seq_addr", imem_addr, 32'(4 * k));
            if (k > 0) check("seq_drained_instr", if_instr, NOP);
            tick();
            tick();
            check("seq_valid",   32'(if_valid), 32'd1);
            check("seq_pc",      if_pc, 32'(4 * k));
            check("seq_instr",   if_instr, rdata_of(32'(4 * k)));
            check("seq_req_low", 32'(imem_req), 32'd0);
            tick();
        end

        // Backpressure: skid catches 0x4, no third request
        restart();
        tick(); tick(); tick();
        check("bp_first_pc", if_pc, 32'h0);
        if_ready = 1'b0;
        tick();
        check("bp_req4", imem_addr, 32'h4);
        tick();
        tick();
        check("bp_hold_valid", 32'(if_valid), 32'd1);
        check("bp_hold_pc7",   if_pc, 32'h0);
        check("bp_noreq7",     32'(imem_req), 32'd0);
        tick(); tick();
        check("bp_noreq9",     32'(imem_req), 32'd0);
        tick();
        check("bp_hold_pc10",  if_pc, 32'h0);
        check("bp_hold_instr", if_instr, rdata_of(32'h0));
        if_ready = 1'b1;
        tick();
        check("bp_skid_valid", 32'(if_valid), 32'd1);
        check("bp_skid_pc",    if_pc, 32'h4);
        check("bp_skid_instr", if_instr, rdata_of(32'h4));
        check("bp_skid_noreq", 32'(imem_req), 32'd0);
        tick();
        check("bp_req8",       32'(imem_req), 32'd1);
        check("bp_req8_addr",  imem_addr, 32'h8);
        check("bp_empty",      32'(if_valid), 32'd0);

        // Branch during a 3-cycle request: response dropped
        mem_lat = 3;
        restart();
        repeat (11) tick();
        check("br_req8", imem_addr, 32'h8);
        tick();
        branch_ctrl   = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_ctrl = 1'b0;
        check("br_hold_req",  32'(imem_req), 32'd1);
        check("br_hold_addr", imem_addr, 32'h8);
        check("br_valid14",   32'(if_valid), 32'd0);
        tick();
        check("br_ack_addr",  imem_addr, 32'h8);
        tick();
        check("br_req_low",   32'(imem_req), 32'd0);
        check("br_dropped",   32'(if_valid), 32'd0);
        tick();
        check("br_new_req",   32'(imem_req), 32'd1);
        check("br_new_addr",  imem_addr, 32'h40);
        check("br_valid17",   32'(if_valid), 32'd0);

        // Branch and jump together with an ack: jump wins, data discarded
        mem_lat = 1;
        restart();
        tick();
        check("bj_req0", imem_addr, 32'h0);
        tick();
        branch_ctrl   = 1'b1;
        branch_target = 32'h80;
        jump          = 1'b1;
        jump_target   = 32'h200;
        tick();
        branch_ctrl = 1'b0;
        jump        = 1'b0;
        check("bj_valid", 32'(if_valid), 32'd0);
        check("bj_instr", if_instr, NOP);
        check("bj_req",   32'(imem_req), 32'd0);
        tick();
        check("bj_new_req",  32'(imem_req), 32'd1);
        check("bj_new_addr", imem_addr, 32'h200);

        // Misaligned jump target from WAIT
        restart();
        tick();
        jump        = 1'b1;
        jump_target = 32'h42;
        tick();
        jump = 1'b0;
        check("mis_held_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_trap_hi", 32'(misalign_trap), 32'd1);
`endif
        tick();
        check("mis_req_low", 32'(imem_req), 32'd0);
        check("mis_valid",   32'(if_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_trap_lo", 32'(misalign_trap), 32'd0);
`endif
        tick();
        check("mis_new_req", 32'(imem_req), 32'd1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_new_addr", imem_addr, 32'h100);
`else
        check("mis_new_addr", imem_addr, 32'h40);
`endif

        // Jump from IDLE to the last word: PC wraps to 0
        restart();
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        check("wrap_idle_noreq", 32'(imem_req), 32'd0);
        tick();
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_pc",    if_pc, 32'hFFFF_FFFC);
        check("wrap_instr", if_instr, rdata_of(32'hFFFF_FFFC));
        tick();
        check("wrap_next_addr", imem_addr, 32'h0);

        // Reset asserted while a request is outstanding
        restart();
        if_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check("rw_pre_req",   32'(imem_req), 32'd1);
        check("rw_pre_valid", 32'(if_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_req",   32'(imem_req), 32'd0);
        check("rw_valid", 32'(if_valid), 32'd0);
        check("rw_addr",  imem_addr, 32'h0);
        check("rw_instr", if_instr, NOP);
        tick();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        tick();
        check("rw_boot_noreq", 32'(imem_req), 32'd0);
        tick();
        check("rw_first_req",  32'(imem_req), 32'd1);
        check("rw_first_addr", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
